regfile_alu_datapath: RTL

- Datapath consumed directly downstream of the Fibonacci control FSM.
- Takes its per-cycle control word (immediate, enable, control1, control2, imm_control, opcode, buff_en) and owns the register file, the left/right operand latches, the ALU, the flag register and the bus driver.
- Produces the ALU bus value and status flags.
- Exposes a read-only debug port so the bench can inspect register contents.

---
 rtl/regfile_alu_datapath.sv | 138 +++++++++++++
 1 files changed

// File: rtl/regfile_alu_datapath.sv
// Register file, operand latches, ALU, flag register and bus driver sitting
// behind the Fibonacci control FSM; one control word consumed per cycle.

module regfile_alu_datapath_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module regfile_alu_datapath #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    immediate,
  input  logic [NUM_REGS-1:0] enable,
  input  logic [4:0]          control1,
  input  logic [4:0]          control2,
  input  logic                imm_control,
  input  logic [7:0]          opcode,
  input  logic                buff_en,
  output logic [WIDTH-1:0]    bus_data,
  output logic                bus_oe,
  output logic [3:0]          flags,
  output logic                err,
  input  logic [3:0]          dbg_sel,
  output logic [WIDTH-1:0]    dbg_data
);
  localparam logic [7:0] OP_AND = 8'h01;
  localparam logic [7:0] OP_OR  = 8'h02;
  localparam logic [7:0] OP_XOR = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h05;
  localparam logic [7:0] OP_SUB = 8'h09;
  localparam logic [7:0] OP_CMP = 8'h0B;
  localparam logic [7:0] OP_MOV = 8'h0D;
  localparam logic [7:0] OP_LSH = 8'h0E;
  localparam int MSB = WIDTH - 1;

  logic [NUM_REGS-1:0][WIDTH-1:0] r;
  logic [NUM_REGS-1:0]            we;
  logic [WIDTH-1:0]               a_q, b_q, a_nxt, b_nxt, res;
  logic [WIDTH:0]                 sum, diff;
  logic                           a_bad, b_bad, legal, is_cmp, c_f, v_f;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      regfile_alu_datapath_cell #(.WIDTH(WIDTH)) u_cell (
        .clk(clk), .reset(reset), .we(we[g]), .d(res), .q(r[g])
      );
    end
  endgenerate

  // Operand selects read the pre-edge register file, so a same-edge write
  // to the selected register is not visible until the following load.
  always_comb begin
    a_nxt = a_q;
    a_bad = int'(control1) > NUM_REGS;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(control1) == i + 1) a_nxt = r[i];
  end

  always_comb begin
    b_nxt = b_q;
    b_bad = 1'b0;
    if (imm_control) begin
      b_nxt = immediate;
    end else begin
      b_bad = int'(control2) > NUM_REGS;
      for (int i = 0; i < NUM_REGS; i++)
        if (int'(control2) == i + 1) b_nxt = r[i];
    end
  end

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    res   = '0;
    c_f   = 1'b0;
    v_f   = 1'b0;
    legal = 1'b1;
    case (opcode)
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_ADD: begin
        res = sum[MSB:0];
        c_f = sum[WIDTH];
        v_f = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_CMP: begin
        res = diff[MSB:0];
        c_f = diff[WIDTH];
        v_f = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_MOV: res = b_q;
      OP_LSH: res = a_q << b_q[3:0];
      default: legal = 1'b0;
    endcase
  end

  assign is_cmp   = (opcode == OP_CMP);
  // Gated by reset so the bus releases immediately, without waiting for an edge.
  assign bus_oe   = reset & buff_en & ~is_cmp;
  assign bus_data = bus_oe ? res : '0;
  assign we       = (buff_en && legal && !is_cmp) ? enable : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      flags <= '0;
      err   <= 1'b0;
    end else begin
      a_q <= a_nxt;
      b_q <= b_nxt;
      if (buff_en && legal) flags <= {c_f, res == '0, res[MSB], v_f};
      err <= err | a_bad | b_bad | (buff_en & ~legal);
    end
  end

  always_comb begin
    dbg_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(dbg_sel) == i) dbg_data = r[i];
  end
endmodule
